capture_core: RTL and testbench

- Parametrised capture engine for the logic analyser: sample divider, mask/value trigger, circular sample RAM with pre/post-trigger windowing, and a byte-serialised readout stream.
- Sits between the input synchroniser and the UART transmit mux, replacing the separate sampler and basic trigger.
- Generalises those blocks to wide samples (multi-byte), deep buffers and programmable pre/post-trigger counts.

---
 rtl/capture_pkg.sv | 21 ++
 rtl/sample_ram.sv | 23 ++
 rtl/capture_core.sv | 238 +++++++++++++++++++++++
 tb/tb_capture_core.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture engine: FSM state encoding and
// sample-to-byte sizing used by the readout serialiser.
package capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POST    = 2'd2,
    ST_READOUT = 2'd3
  } state_e;

  function automatic int bytes_per_sample(input int sample_width);
    return sample_width / 8;
  endfunction

  // At least one bit so a single-byte sample still has a legal index register.
  function automatic int byte_idx_width(input int sample_width);
    return (sample_width / 8 > 1) ? $clog2(sample_width / 8) : 1;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample store: synchronous write, registered read
// (one clock latency), array is not reset.
module sample_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/capture_core.sv
// Logic-analyser capture engine: divided sample strobe, mask/value trigger,
// circular RAM with pre/post windowing, byte-serial readout. Defining
// CAPTURE_EDGE_TRIG_EN adds per-bit rising/falling edge triggering (trig_edge).
module capture_core
  import capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 32,
  parameter int DEPTH        = 4096,
  parameter int DIV_WIDTH    = 24,
  parameter int CNT_WIDTH    = $clog2(DEPTH) + 1
) (
  input  logic                    system_clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic [DIV_WIDTH-1:0]    divider,
  input  logic [SAMPLE_WIDTH-1:0] trig_mask,
  input  logic [SAMPLE_WIDTH-1:0] trig_value,
`ifdef CAPTURE_EDGE_TRIG_EN
  input  logic [SAMPLE_WIDTH-1:0] trig_edge,
`endif
  input  logic [CNT_WIDTH-1:0]    read_count,
  input  logic [CNT_WIDTH-1:0]    delay_count,
  input  logic                    arm,
  input  logic                    abort,
  output logic [7:0]              tx_byte,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    triggered,
  output logic                    done,
  output logic [1:0]              dbg_state_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int BPS = bytes_per_sample(SAMPLE_WIDTH);
  localparam int BW  = byte_idx_width(SAMPLE_WIDTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(DEPTH);
  localparam logic [BW-1:0]        LAST_BYTE = BW'(BPS - 1);

  state_e                  state_q, state_d;
  logic [DIV_WIDTH-1:0]    div_q, div_d, div_cnt_q, div_cnt_d;
  logic [SAMPLE_WIDTH-1:0] mask_q, mask_d, value_q, value_d;
  logic [CNT_WIDTH-1:0]    read_q, read_d, delay_q, delay_d;
  logic [CNT_WIDTH-1:0]    fill_q, fill_d, post_q, post_d, rem_q, rem_d, len;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]           byte_idx_q, byte_idx_d;
  logic                    fetch_q, fetch_d, tx_valid_q, tx_valid_d;
  logic                    trig_q, trig_d, first_q, first_d;
  logic                    strobe_run, strobe, we, match;
  logic [SAMPLE_WIDTH-1:0] rd_data, rd_shift;

`ifdef CAPTURE_EDGE_TRIG_EN
  logic [SAMPLE_WIDTH-1:0] edge_q, edge_d, prev_q, prev_d, edge_bits, edge_hit;
  assign edge_bits = mask_q & edge_q;
  assign edge_hit  = (prev_q ^ value_q) & ~(data_in ^ value_q);
  assign match = (((data_in ^ value_q) & mask_q & ~edge_q) == '0)
              && ((edge_bits & ~edge_hit) == '0)
              && ((edge_bits == '0) || !first_q);
`else
  assign match = ((data_in ^ value_q) & mask_q) == '0;
`endif

  sample_ram #(.WIDTH(SAMPLE_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (system_clock),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    mask_d     = mask_q;
    value_d    = value_q;
    read_d     = read_q;
    delay_d    = delay_q;
    fill_d     = fill_q;
    post_d     = post_q;
    rem_d      = rem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_idx_d = byte_idx_q;
    fetch_d    = fetch_q;
    tx_valid_d = tx_valid_q;
    trig_d     = trig_q;
    first_d    = first_q;
`ifdef CAPTURE_EDGE_TRIG_EN
    edge_d     = edge_q;
    prev_d     = prev_q;
`endif
    we         = 1'b0;
    done       = 1'b0;
    len        = (read_q < fill_q) ? read_q : fill_q;
    strobe_run = (state_q == ST_ARMED) || (state_q == ST_POST);
    strobe     = strobe_run && (div_cnt_q == div_q);
    if (strobe_run) div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;

    if (abort) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
      fetch_d    = 1'b0;
      trig_d     = 1'b0;
      div_cnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (arm) begin
          div_d     = divider;
          mask_d    = trig_mask;
          value_d   = trig_value;
          read_d    = read_count;
          delay_d   = (delay_count > DEPTH_C) ? DEPTH_C : delay_count;
`ifdef CAPTURE_EDGE_TRIG_EN
          edge_d    = trig_edge;
`endif
          wr_ptr_d  = '0;
          fill_d    = '0;
          div_cnt_d = '0;
          first_d   = 1'b1;
          state_d   = ST_ARMED;
        end
        ST_ARMED: if (strobe) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (fill_q != DEPTH_C) fill_d = fill_q + 1'b1;
          first_d  = 1'b0;
`ifdef CAPTURE_EDGE_TRIG_EN
          prev_d   = data_in;
`endif
          if (match) begin
            // The trigger sample itself is the first of the delay_count samples.
            trig_d  = 1'b1;
            post_d  = (delay_q == '0) ? '0 : delay_q - 1'b1;
            state_d = ST_POST;
          end
        end
        ST_POST: begin
          if (post_q == '0) begin
            rem_d      = len;
            rd_ptr_d   = wr_ptr_q - len[AW-1:0];
            fetch_d    = (len != '0);
            byte_idx_d = '0;
            state_d    = ST_READOUT;
          end else if (strobe) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q != DEPTH_C) fill_d = fill_q + 1'b1;
            post_d   = post_q - 1'b1;
          end
        end
        ST_READOUT: begin
          // Handshake: tx_byte/tx_valid hold until a cycle with
          // tx_valid && tx_ready; that cycle transfers exactly one byte.
          if (fetch_q) begin
            fetch_d    = 1'b0;
            tx_valid_d = 1'b1;
            byte_idx_d = '0;
          end else if (tx_valid_q) begin
            if (tx_ready) begin
              if (byte_idx_q == LAST_BYTE) begin
                tx_valid_d = 1'b0;
                rem_d      = rem_q - 1'b1;
                rd_ptr_d   = rd_ptr_q + 1'b1;
                fetch_d    = (rem_q != 1);
              end else begin
                byte_idx_d = byte_idx_q + 1'b1;
              end
            end
          end else begin
            done    = 1'b1;
            trig_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      div_cnt_q  <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      read_q     <= '0;
      delay_q    <= '0;
      fill_q     <= '0;
      post_q     <= '0;
      rem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_idx_q <= '0;
      fetch_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      trig_q     <= 1'b0;
      first_q    <= 1'b0;
`ifdef CAPTURE_EDGE_TRIG_EN
      edge_q     <= '0;
      prev_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      read_q     <= read_d;
      delay_q    <= delay_d;
      fill_q     <= fill_d;
      post_q     <= post_d;
      rem_q      <= rem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_idx_q <= byte_idx_d;
      fetch_q    <= fetch_d;
      tx_valid_q <= tx_valid_d;
      trig_q     <= trig_d;
      first_q    <= first_d;
`ifdef CAPTURE_EDGE_TRIG_EN
      edge_q     <= edge_d;
      prev_q     <= prev_d;
`endif
    end
  end

  // RAM output is held steady because rd_ptr only moves after a sample's last byte.
  assign rd_shift    = rd_data >> {byte_idx_q, 3'b000};
  assign tx_byte     = tx_valid_q ? rd_shift[7:0] : 8'h00;
  assign tx_valid    = tx_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign triggered   = trig_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_capture_core.sv
// Directed bench for capture_core (32-bit samples, 16-entry RAM): expected
// readout bytes are queued up front and popped by a monitor on each transfer.
module tb_capture_core;

  localparam int W = 32;
  localparam int D = 16;
  localparam int DW = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  data_in = '0;
  logic [DW-1:0] divider = '0;
  logic [W-1:0]  trig_mask = '0;
  logic [W-1:0]  trig_value = '0;
  logic [W-1:0]  trig_edge = '0;
  logic [CW-1:0] read_count = '0;
  logic [CW-1:0] delay_count = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          tx_ready = 1'b1;
  logic [7:0]    tx_byte;
  logic          tx_valid, busy, triggered, done;
  logic [1:0]    dbg_state;

  logic [7:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;
  int done_cnt = 0;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_byte = '0;

  capture_core #(.SAMPLE_WIDTH(W), .DEPTH(D), .DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .system_clock (clk),
    .reset        (rst),
    .data_in      (data_in),
    .divider      (divider),
    .trig_mask    (trig_mask),
    .trig_value   (trig_value),
`ifdef CAPTURE_EDGE_TRIG_EN
    .trig_edge    (trig_edge),
`endif
    .read_count   (read_count),
    .delay_count  (delay_count),
    .arm          (arm),
    .abort        (abort),
    .tx_byte      (tx_byte),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .triggered    (triggered),
    .done         (done),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    err_cnt++;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (hold_pending) begin
        vec_cnt++;
        if (!tx_valid || tx_byte !== hold_byte) begin
          err_cnt++;
          $display("FAIL stall_hold: got valid=%0b byte=%02h, need valid=1 byte=%02h",
                   tx_valid, tx_byte, hold_byte);
        end
      end
      hold_pending = tx_valid && !tx_ready && !abort;
      hold_byte    = tx_byte;
      if (tx_valid && tx_ready) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL unexpected_byte: got %02h, none expected", tx_byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (tx_byte !== e) begin
            err_cnt++;
            $display("FAIL tx_byte: got %02h, expected %02h", tx_byte, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_sample(input logic [W-1:0] s);
    for (int b = 0; b < W / 8; b++) exp_q.push_back(s[b*8 +: 8]);
  endtask

  task automatic start_cap(input logic [DW-1:0] div, input logic [W-1:0] mask,
                           input logic [W-1:0] value, input logic [CW-1:0] rd,
                           input logic [CW-1:0] dly);
    divider = div; trig_mask = mask; trig_value = value;
    read_count = rd; delay_count = dly;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic feed(input logic [W-1:0] v, input int hold);
    data_in = v;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int start, input string name);
    int n = 0;
    while (done_cnt == start && n < 2000) begin
      @(posedge clk); n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_done_once"}, done_cnt - start, 1);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_trig_clr"}, triggered, 0);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  task automatic wait_tx_valid(input string name);
    int n = 0;
    while (!tx_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_tx_valid_up"}, tx_valid, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_triggered", triggered, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);

    // T1: divider 0, trigger on 5 with delay 4 -> samples 1..8
    for (int k = 1; k <= 8; k++) push_sample(W'(k));
    s = done_cnt;
    start_cap(0, 32'hFF, 32'h05, 8, 4);
    check("t1_busy", busy, 1);
    for (int k = 1; k <= 5; k++) feed(W'(k), 1);
    check("t1_triggered", triggered, 1);
    for (int k = 6; k <= 8; k++) feed(W'(k), 1);
    feed(32'h0000_00EE, 1);
    wait_done(s, "t1");

    // T2: divider 2 (strobe every 3rd clock), mask 0, delay 2 -> 2 samples, LSB first
    exp_q.push_back(8'hD4); exp_q.push_back(8'hC3); exp_q.push_back(8'hB2); exp_q.push_back(8'hA1);
    exp_q.push_back(8'h44); exp_q.push_back(8'h33); exp_q.push_back(8'h22); exp_q.push_back(8'h11);
    s = done_cnt;
    start_cap(2, 32'h0, 32'h0, 2, 2);
    feed(32'hA1B2C3D4, 3);
    feed(32'h11223344, 3);
    feed(32'h55555555, 3);
    wait_done(s, "t2");

    // T3: read 20 but only 6 samples written; config changes after arm ignored
    for (int k = 1; k <= 6; k++) push_sample(W'(k * 10));
    s = done_cnt;
    start_cap(0, 32'hFF, 32'd30, 20, 4);
    trig_mask = '0; read_count = 1;
    for (int k = 1; k <= 6; k++) feed(W'(k * 10), 1);
    feed(32'h0, 1);
    wait_done(s, "t3");

    // T4: 40 pre-trigger strobes wrap the RAM; stall the stream for 50 clocks
    for (int k = 26; k <= 40; k++) push_sample(W'(k));
    push_sample(32'hCAFE0000);
    s = done_cnt;
    start_cap(0, 32'hFFFFFFFF, 32'hCAFE0000, 16, 1);
    for (int k = 1; k <= 40; k++) feed(W'(k), 1);
    feed(32'hCAFE0000, 1);
    feed(32'h0, 1);
    begin
      int n = 0;
      while (exp_q.size() > 50 && n < 1000) begin
        @(posedge clk); #1; n++;
      end
    end
    tx_ready = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("t4_stall_valid", tx_valid, 1);
    tx_ready = 1'b1;
    wait_done(s, "t4");

    // T5: abort during POST
    s = done_cnt;
    start_cap(0, 32'h0, 32'h0, 4, 10);
    for (int k = 0; k < 3; k++) feed(W'(k), 1);
    check("t5_in_post", dbg_state, 2);
    check("t5_triggered", triggered, 1);
    pulse_abort();
    check("t5_state", dbg_state, 0);
    check("t5_busy", busy, 0);
    check("t5_trig_clr", triggered, 0);
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt - s, 0);

    // T6: abort during READOUT with a byte pending
    s = done_cnt;
    tx_ready = 1'b0;
    start_cap(0, 32'h0, 32'h0, 2, 1);
    feed(32'h12345678, 1);
    wait_tx_valid("t6");
    check("t6_first_byte", tx_byte, 8'h78);
    pulse_abort();
    check("t6_tx_valid_drop", tx_valid, 0);
    check("t6_busy", busy, 0);
    tx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t6_no_done", done_cnt - s, 0);

    // T7: arm and abort together -> stays idle
    arm = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0; abort = 1'b0;
    check("t7_state", dbg_state, 0);
    check("t7_busy", busy, 0);

    // T8: read_count 0 -> done with no bytes
    s = done_cnt;
    start_cap(0, 32'h0, 32'h0, 0, 0);
    feed(32'h99, 1);
    wait_done(s, "t8");

`ifdef CAPTURE_EDGE_TRIG_EN
    // T9: rising edge on bit 7 required; bit 7 already high at arm
    trig_edge = 32'h80;
    push_sample(32'h03); push_sample(32'h84);
    s = done_cnt;
    start_cap(0, 32'h80, 32'h80, 2, 1);
    feed(32'h80, 1); feed(32'h81, 1); feed(32'h82, 1);
    check("t9_no_trig_level", triggered, 0);
    feed(32'h03, 1);
    check("t9_no_trig_low", triggered, 0);
    feed(32'h84, 1);
    feed(32'h0, 1);
    wait_done(s, "t9");
    trig_edge = '0;
`endif

    // T10: asynchronous reset mid-readout
    tx_ready = 1'b0;
    start_cap(0, 32'h0, 32'h0, 1, 1);
    feed(32'h000000AA, 1);
    wait_tx_valid("t10");
    rst = 1'b1;
    #2;
    check("t10_rst_tx_valid", tx_valid, 0);
    check("t10_rst_tx_byte", tx_byte, 0);
    check("t10_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t10_idle_after", dbg_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
